pipe_latch_queue: RTL and testbench

- Parametrised successor to the single-slot start/done pipeline latch: a DEPTH-entry in-order holding queue between a producer stage (iStart) and a consumer stage (iDone).
- Lets a producer issue up to DEPTH jobs ahead of a slower consumer instead of stalling after one.
- DEPTH=1 with TRACK_IDLE=1 reproduces the single-slot latch cycle-for-cycle.
- Adds occupancy, full and sticky overflow status.

---
 rtl/pipe_latch_queue_pkg.sv | 33 +++
 rtl/pipe_latch_queue_ptr.sv | 41 ++++
 rtl/pipe_latch_queue.sv | 148 ++++++++++++++
 tb/tb_pipe_latch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_latch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  pipe_latch_queue_pkg
//  Width helpers shared by queue-style blocks (count and pointer sizing).
//  Rev 1.0
// ============================================================================
package pipe_latch_queue_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    // Never zero-width, even when a single entry makes the pointer constant.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_latch_queue_ptr.sv
`default_nettype none
// ============================================================================
//  pipe_latch_ptr
//  Modulo-DEPTH wrapping pointer with increment enable and async reset.
//  Rev 1.0
// ============================================================================
module pipe_latch_ptr
    import pipe_latch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inc_i,
    output logic [ptr_width(DEPTH)-1:0] ptr_o
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = PW'(wrap_inc(int'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/pipe_latch_queue.sv
`default_nettype none
// ============================================================================
//  pipe_latch_queue
//  DEPTH-entry in-order start/done holding queue with registered head.
//  Rev 1.0
// ============================================================================
module pipe_latch_queue
    import pipe_latch_queue_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter bit TRACK_IDLE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iStart,
    input  logic                        iDone,
    input  logic [WIDTH-1:0]            iData,
    input  logic                        iClrOvf,
    output logic [WIDTH-1:0]            oData,
    output logic                        oLocked,
    output logic                        oFull,
    output logic [cnt_width(DEPTH)-1:0] oCount,
    output logic                        oOverflow
);

    localparam int             CW       = cnt_width(DEPTH);
    localparam int             PW       = ptr_width(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [WIDTH-1:0] next_entry;

    logic             pop;
    logic             push;
    logic             drop;

    assign pop  = iDone  & (count_q != '0);
    assign push = iStart & ((count_q != FULL_CNT) | pop);
    assign drop = iStart & (count_q == FULL_CNT) & ~pop;

    pipe_latch_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    pipe_latch_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    assign rd_nxt = PW'(wrap_inc(int'(rd_ptr), DEPTH));

    // Entry that becomes the head once the current one is popped.
    always_comb begin
        next_entry = mem_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_nxt == PW'(i)) begin
                next_entry = mem_q[i];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (pop && !push) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (iClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    // A pop that empties the queue leaves the popped value on the head.
    always_comb begin
        head_d = head_q;
        if (count_q == '0) begin
            if (push || TRACK_IDLE) begin
                head_d = iData;
            end
        end else if (pop) begin
            if (count_q == ONE_CNT) begin
                if (push) begin
                    head_d = iData;
                end
            end else begin
                head_d = next_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i))) begin
                    mem_q[i] <= iData;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oData     = head_q;
    assign oCount    = count_q;
    assign oLocked   = (count_q != '0);
    assign oFull     = (count_q == FULL_CNT);
    assign oOverflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_latch_queue.sv
`default_nettype none
// ============================================================================
//  tb_pipe_latch_queue
//  Four queue configurations driven in parallel against a list-based model.
//  Rev 1.0
// ============================================================================
module tb_pipe_latch_queue;

    logic       clk;
    logic       rst;
    logic       start;
    logic       done;
    logic [7:0] din;
    logic       clr;

    logic [7:0] dA, dB, dC, dE;
    logic [0:0] cA;
    logic [2:0] cB, cE;
    logic [1:0] cC;
    logic       lA, lB, lC, lE;
    logic       fA, fB, fC, fE;
    logic       oA, oB, oC, oE;

    int total;
    int passed;

    // Model: per-instance ordered job list (index 0 = oldest), shifted on pop.
    logic [7:0] mbuf  [4][8];
    int         mlen  [4];
    logic [7:0] mhead [4];
    bit         movf  [4];

    pipe_latch_queue #(.WIDTH(8), .DEPTH(1), .TRACK_IDLE(1'b1)) u_a (
        .clk(clk), .rst(rst), .iStart(start), .iDone(done), .iData(din), .iClrOvf(clr),
        .oData(dA), .oLocked(lA), .oFull(fA), .oCount(cA), .oOverflow(oA));
    pipe_latch_queue #(.WIDTH(8), .DEPTH(4), .TRACK_IDLE(1'b1)) u_b (
        .clk(clk), .rst(rst), .iStart(start), .iDone(done), .iData(din), .iClrOvf(clr),
        .oData(dB), .oLocked(lB), .oFull(fB), .oCount(cB), .oOverflow(oB));
    pipe_latch_queue #(.WIDTH(8), .DEPTH(3), .TRACK_IDLE(1'b1)) u_c (
        .clk(clk), .rst(rst), .iStart(start), .iDone(done), .iData(din), .iClrOvf(clr),
        .oData(dC), .oLocked(lC), .oFull(fC), .oCount(cC), .oOverflow(oC));
    pipe_latch_queue #(.WIDTH(8), .DEPTH(4), .TRACK_IDLE(1'b0)) u_e (
        .clk(clk), .rst(rst), .iStart(start), .iDone(done), .iData(din), .iClrOvf(clr),
        .oData(dE), .oLocked(lE), .oFull(fE), .oCount(cE), .oOverflow(oE));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit track_of(input int k);
        return (k != 3);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act == exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mlen[k]  = 0;
            mhead[k] = 8'h00;
            movf[k]  = 1'b0;
            for (int j = 0; j < 8; j++) mbuf[k][j] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int         d;
            bit         is_full, pop, push, drop;
            logic [7:0] popped;
            d       = depth_of(k);
            is_full = (mlen[k] == d);
            pop     = done && (mlen[k] > 0);
            push    = start && (!is_full || pop);
            drop    = start && is_full && !pop;
            popped  = mbuf[k][0];
            if (pop) begin
                for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
                mlen[k] = mlen[k] - 1;
            end
            if (push) begin
                mbuf[k][mlen[k]] = din;
                mlen[k] = mlen[k] + 1;
            end
            if (mlen[k] > 0)      mhead[k] = mbuf[k][0];
            else if (pop)         mhead[k] = popped;
            else if (track_of(k)) mhead[k] = din;
            if (drop)      movf[k] = 1'b1;
            else if (clr)  movf[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        int ad[4];
        int ac[4];
        int al[4];
        int af[4];
        int ao[4];
        ad = '{int'(dA), int'(dB), int'(dC), int'(dE)};
        ac = '{int'(cA), int'(cB), int'(cC), int'(cE)};
        al = '{int'(lA), int'(lB), int'(lC), int'(lE)};
        af = '{int'(fA), int'(fB), int'(fC), int'(fE)};
        ao = '{int'(oA), int'(oB), int'(oC), int'(oE)};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("data[%0d]", k),   ad[k], int'(mhead[k]));
            chk($sformatf("count[%0d]", k),  ac[k], mlen[k]);
            chk($sformatf("locked[%0d]", k), al[k], int'(mlen[k] > 0));
            chk($sformatf("full[%0d]", k),   af[k], int'(mlen[k] == depth_of(k)));
            chk($sformatf("ovf[%0d]", k),    ao[k], int'(movf[k]));
        end
    endtask

    task automatic cycle(input bit s, input bit dn, input logic [7:0] dt, input bit c);
        start = s;
        done  = dn;
        din   = dt;
        clr   = c;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        done   = 1'b0;
        din    = 8'h00;
        clr    = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset data",   int'(dB), 0);
        chk("reset count",  int'(cB), 0);
        chk("reset locked", int'(lB), 0);
        do_reset();

        // Single-slot lockstep (DEPTH=1)
        cycle(1'b1, 1'b0, 8'h5A, 1'b0);
        chk("d1 push data", int'(dA), 'h5A);
        chk("d1 push lock", int'(lA), 1);
        cycle(1'b1, 1'b1, 8'h33, 1'b0);
        chk("d1 swap data", int'(dA), 'h33);
        chk("d1 swap lock", int'(lA), 1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("d1 pop lock", int'(lA), 0);

        // Fill DEPTH=4, overflow, drain
        do_reset();
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        cycle(1'b1, 1'b0, 8'h44, 1'b0);
        chk("fill count", int'(cB), 4);
        chk("fill full",  int'(fB), 1);
        chk("fill head",  int'(dB), 'h11);
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        chk("drop ovf",   int'(oB), 1);
        chk("drop count", int'(cB), 4);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain 1", int'(dB), 'h22);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain 2", int'(dB), 'h33);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain 3", int'(dB), 'h44);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain lock", int'(lB), 0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf clear", int'(oB), 0);

        // Full with simultaneous push and pop
        do_reset();
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        cycle(1'b1, 1'b0, 8'h44, 1'b0);
        cycle(1'b1, 1'b1, 8'h66, 1'b0);
        chk("pp count", int'(cB), 4);
        chk("pp ovf",   int'(oB), 0);
        chk("pp head",  int'(dB), 'h22);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pp 33", int'(dB), 'h33);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pp 44", int'(dB), 'h44);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pp 66", int'(dB), 'h66);

        // Wrap-around on DEPTH=3
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            chk("wrap head", int'(dC), i);
            chk("wrap bound", int'(cC <= 2'd3), 1);
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk("wrap ovf", int'(oC), 0);

        // Idle behaviour after the queue empties
        do_reset();
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("idle popped t1", int'(dB), 'h77);
        chk("idle popped t0", int'(dE), 'h77);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            chk("idle track", int'(dB), 'hA0 + i);
            chk("idle hold",  int'(dE), 'h77);
            chk("idle count", int'(cB), 0);
        end

        // Asynchronous reset between edges at count=2
        do_reset();
        cycle(1'b1, 1'b0, 8'h01, 1'b0);
        cycle(1'b1, 1'b0, 8'h02, 1'b0);
        chk("pre-arst count", int'(cB), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst data",   int'(dB), 0);
        chk("arst count",  int'(cB), 0);
        chk("arst locked", int'(lB), 0);
        chk("arst ovf",    int'(oA), 0);
        model_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h9C, 1'b0);
        chk("post-arst data",  int'(dB), 'h9C);
        chk("post-arst count", int'(cB), 1);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                  8'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
